// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial ripple adder sequencer.
// One full-adder cell, LSB first, one bit per clock.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] s_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             s;
  logic             c;
  logic             last;
  logic             accept;

  assign s = a_sr[0] ^ b_sr[0] ^ carry;
  assign c = (a_sr[0] & b_sr[0]) |
             (b_sr[0] & carry) |
             (a_sr[0] & carry);
  assign last   = (cnt == LAST);
  assign accept = (state == IDLE) && start;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // Next-state: RUN for WIDTH bits, DONE for one cycle.
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (start) nxt = RUN;
      RUN:     if (last) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Operand shift, carry chain and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr  <= '0;
      b_sr  <= '0;
      s_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      a_sr  <= a;
      b_sr  <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      s_sr  <= {s, s_sr[WIDTH-1:1]};
      carry <= c;
      cnt   <= cnt + 1'b1;
      if (last) begin
        sum  <= {s, s_sr[WIDTH-1:1]};
        cout <= c;
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: randomized and directed checks
// of serial_adder_ctrl at WIDTH 8, 4 and 2.
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       st8, st4, st2;
  logic [7:0] a8, b8, s8;
  logic [3:0] a4, b4, s4;
  logic [1:0] a2, b2, s2;
  logic       ci8, ci4, ci2;
  logic       bz8, bz4, bz2;
  logic       dn8, dn4, dn2;
  logic       co8, co4, co2;

  int npass = 0;
  int ntot  = 0;

  serial_adder_ctrl #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(st8),
    .a(a8), .b(b8), .cin(ci8),
    .busy(bz8), .done(dn8), .sum(s8), .cout(co8)
  );

  serial_adder_ctrl #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(st4),
    .a(a4), .b(b4), .cin(ci4),
    .busy(bz4), .done(dn4), .sum(s4), .cout(co4)
  );

  serial_adder_ctrl #(.WIDTH(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(st2),
    .a(a2), .b(b2), .cin(ci2),
    .busy(bz2), .done(dn2), .sum(s2), .cout(co2)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h want %0h",
                  tag, got, exp);
  endtask

  function automatic logic [63:0] rd_sum(int w);
    case (w)
      8:       return 64'(s8);
      4:       return 64'(s4);
      default: return 64'(s2);
    endcase
  endfunction

  function automatic logic rd_cout(int w);
    case (w)
      8:       return co8;
      4:       return co4;
      default: return co2;
    endcase
  endfunction

  function automatic logic rd_busy(int w);
    case (w)
      8:       return bz8;
      4:       return bz4;
      default: return bz2;
    endcase
  endfunction

  function automatic logic rd_done(int w);
    case (w)
      8:       return dn8;
      4:       return dn4;
      default: return dn2;
    endcase
  endfunction

  task automatic drv(input int w, input logic s,
                     input logic [31:0] av,
                     input logic [31:0] bv,
                     input logic ci);
    case (w)
      8: begin st8 = s; a8 = av[7:0]; b8 = bv[7:0]; ci8 = ci; end
      4: begin st4 = s; a4 = av[3:0]; b4 = bv[3:0]; ci4 = ci; end
      default: begin
        st2 = s; a2 = av[1:0]; b2 = bv[1:0]; ci2 = ci;
      end
    endcase
  endtask

  // One add from an IDLE negedge; returns on an IDLE negedge.
  task automatic op(input int w,
                    input logic [31:0] av,
                    input logic [31:0] bv,
                    input logic ci);
    longint m, r;
    int     nb;
    bit     seen;
    m = (longint'(1) << w) - 1;
    r = (longint'(av) & m) + (longint'(bv) & m) + longint'(ci);
    drv(w, 1'b1, av, bv, ci);
    @(negedge clk);
    drv(w, 1'b0, $urandom, $urandom, 1'($urandom));
    nb = 0;
    seen = 0;
    for (int k = 0; k < 64 && !seen; k++) begin
      if (rd_done(w)) seen = 1;
      else begin
        if (rd_busy(w)) nb++;
        @(negedge clk);
      end
    end
    chk("done_seen", 64'(seen), 64'd1);
    if (seen) begin
      chk("busy_cycles", 64'(nb), 64'(w));
      chk("busy_in_done", 64'(rd_busy(w)), 64'd0);
      chk("sum", rd_sum(w), 64'(r & m));
      chk("cout", 64'(rd_cout(w)), 64'((r >> w) & 1));
      @(negedge clk);
      chk("done_width", 64'(rd_done(w)), 64'd0);
    end
  endtask

  logic [7:0] ha [0:31];
  logic [7:0] hb [0:31];
  logic       hc [0:31];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    longint r;
    int     nd;
    rst_n = 1'b0;
    drv(8, 1'b0, 0, 0, 1'b0);
    drv(4, 1'b0, 0, 0, 1'b0);
    drv(2, 1'b0, 0, 0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_sum8", 64'(s8), 64'd0);
    chk("rst_cout8", 64'(co8), 64'd0);
    chk("rst_busy8", 64'(bz8), 64'd0);
    chk("rst_done8", 64'(dn8), 64'd0);
    chk("rst_busy4", 64'(bz4), 64'd0);
    chk("rst_sum2", 64'(s2), 64'd0);

    op(8, 32'hFF, 32'h01, 1'b0);
    op(8, 32'h55, 32'hAA, 1'b1);
    op(8, 32'h3C, 32'h0F, 1'b0);
    repeat (5) @(negedge clk);
    chk("sum_hold", 64'(s8), 64'h4B);
    chk("cout_hold", 64'(co8), 64'd0);

    for (int i = 0; i < 40; i++)
      op(8, $urandom, $urandom, 1'($urandom));

    // start held high; accepts every WIDTH+2 edges
    for (int k = 0; k <= 30; k++) begin
      @(negedge clk);
      if (k > 0) begin
        int e;
        e = k - 1;
        chk("hold_done", 64'(dn8), 64'((e % 10) == 8));
        if ((e % 10) == 8) begin
          r = longint'(ha[e-8]) + longint'(hb[e-8]) +
              longint'(hc[e-8]);
          chk("hold_sum", 64'(s8), 64'(r & 255));
          chk("hold_cout", 64'(co8), 64'((r >> 8) & 1));
        end
      end
      if (k < 30) begin
        ha[k] = 8'($urandom);
        hb[k] = 8'($urandom);
        hc[k] = 1'($urandom);
        drv(8, 1'b1, 32'(ha[k]), 32'(hb[k]), hc[k]);
      end
    end
    drv(8, 1'b0, 0, 0, 1'b0);
    @(negedge clk);

    // reset during bit 4
    drv(8, 1'b1, 32'hFF, 32'hFF, 1'b0);
    @(negedge clk);
    drv(8, 1'b0, 0, 0, 1'b0);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(bz8), 64'd0);
    chk("mid_rst_done", 64'(dn8), 64'd0);
    chk("mid_rst_sum", 64'(s8), 64'd0);
    chk("mid_rst_cout", 64'(co8), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int k = 0; k < 12; k++) begin
      if (dn8 || bz8) nd++;
      @(negedge clk);
    end
    chk("mid_rst_quiet", 64'(nd), 64'd0);
    op(8, 32'h01, 32'h01, 1'b0);

    for (int i = 0; i < 512; i++)
      op(4, 32'(i & 15), 32'((i >> 4) & 15), 1'(i >> 8));

    op(2, 32'h3, 32'h3, 1'b1);
    for (int i = 0; i < 32; i++)
      op(2, 32'(i & 3), 32'((i >> 2) & 3), 1'(i >> 4));

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial ripple adder built around a single full-adder cell and a registered carry: it adds two WIDTH-bit operands plus carry-in, one bit per clock, LSB first. It is the sequencing stage directly upstream of the full-adder cell. It latches the operands, presents one operand bit pair and the stored carry to the cell each cycle, and collects the cell's sum and carry outputs into a parallel result. It trades latency for area where a WIDTH-bit combinational adder is too large.

## Interface
- WIDTH, default 8, operand and result width in bits; legal range 2..32.

- clk  input  1  rising-edge system clock.
- rst_n  input  1  asynchronous reset, active low; clears all state immediately on assertion.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepting edge only.
- b  input  WIDTH  operand B; captured on the accepting edge only.
- cin  input  1  carry-in; captured on the accepting edge only.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse: sum/cout are valid and newly updated.
- sum  output  WIDTH  registered result, low WIDTH bits of a+b+cin.
- cout  output  1  registered carry-out, bit WIDTH of a+b+cin.

## Operation
- Internal state:
  - a_sr, b_sr, s_sr: WIDTH-bit shift registers.
  - carry: 1 bit.
  - cnt: bit counter, $clog2(WIDTH) bits.
  - FSM: IDLE, RUN, DONE.
- IDLE, start=1:
  - Load a_sr<=a, b_sr<=b, carry<=cin, cnt<=0.
  - Go to RUN.
- IDLE, start=0: hold.
- RUN, every cycle:
  - Full-adder cell inputs are a_sr[0], b_sr[0], carry.
  - s = a_sr[0]^b_sr[0]^carry.
  - c = (a_sr[0]&b_sr[0])|(b_sr[0]&carry)|(a_sr[0]&carry).
  - s_sr <= {s, s_sr[WIDTH-1:1]}.
  - a_sr and b_sr shift right by one; carry<=c; cnt<=cnt+1.
- RUN, cnt==WIDTH-1: on the same edge, sum<={s, s_sr[WIDTH-1:1]}, cout<=c, go to DONE.
- DONE: lasts exactly one cycle, then returns to IDLE unconditionally.
- Decoded outputs: busy = (state==RUN); done = (state==DONE).
- start is ignored in RUN and DONE. There is no queuing: a start held high through DONE is accepted on the first IDLE cycle.
- a/b/cin may change freely after the accepting edge.
- sum/cout change only on the edge entering DONE. They hold their value through IDLE and the next RUN until overwritten.
- Overflow is not flagged separately; cout is the unsigned carry-out.
- Reset (rst_n=0, asynchronous, any state including mid-RUN):
  - state=IDLE, busy=0, done=0, sum=0, cout=0.
  - Shift registers, carry and cnt are cleared.
  - The in-flight operation is discarded with no done pulse.
  - After rst_n deasserts, the first accept is possible at the next rising edge.

## Timing
- Accepting edge E0: start=1 sampled in IDLE.
- busy is high from after E0 until after E(WIDTH), i.e. exactly WIDTH cycles.
- Bit i is processed at edge E(i+1).
- sum/cout update at E(WIDTH). done is high from E(WIDTH) to E(WIDTH+1).
- Earliest next accept is E(WIDTH+2), giving a throughput of one add per WIDTH+2 cycles.
- Latency from start to done assertion: WIDTH cycles.

## Test plan
- After reset (rst_n=0 for 2 cycles, then 1): sum=0, cout=0, busy=0, done=0.
  - Then a=8'hFF, b=8'h01, cin=0, start pulsed: busy high 8 cycles, done pulses after E8, sum=8'h00, cout=1.
- a=8'h55, b=8'hAA, cin=1 -> sum=8'h00, cout=1.
  - a=8'h3C, b=8'h0F, cin=0 -> sum=8'h4B, cout=0.
  - sum stays stable until the next done.
- start=1 held continuously with operands changed every cycle:
  - Only IDLE-cycle values are captured.
  - Accepts occur at E0, E10, E20 for WIDTH=8.
  - Each result matches the operands present at its accepting edge.
- Reset mid-operation: assert rst_n=0 at bit 4 of a=8'hFF, b=8'hFF. Required response:
  - All outputs are zero immediately, asynchronously, with no done pulse.
  - A fresh add a=8'h01, b=8'h01 yields sum=8'h02, cout=0.
- WIDTH=4: exhaustive sweep of all 512 a/b/cin combinations against the reference model {cout,sum}=a+b+cin.
  - Check busy lasts exactly 4 cycles and done exactly 1 cycle per operation.
- WIDTH=2 corner: a=2'b11, b=2'b11, cin=1 -> sum=2'b11, cout=1, done 2 cycles after accept.
